// File: rtl/ssd_pkg.sv
// Shared 7-segment symbol codes used by the lock controller and the scan driver.
// Codes 0x00-0x0F are the hex digits themselves.
package ssd_pkg;

    typedef logic [4:0] sym_t;

    localparam sym_t SYM_BLANK = 5'h10;
    localparam sym_t SYM_DASH  = 5'h11;
    localparam sym_t SYM_L     = 5'h12;
    localparam sym_t SYM_P     = 5'h13;
    localparam sym_t SYM_n     = 5'h14;
    localparam sym_t SYM_U     = 5'h15;
    localparam sym_t SYM_r     = 5'h16;

    // One display slot as captured at a slot boundary.
    typedef struct packed {
        sym_t code;
        logic blink;
        logic dp;
    } slot_hold_t;

endpackage

// File: rtl/sym_to_seg.sv
// Symbol code to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
// Unassigned codes fall through to blank.
module sym_to_seg
    import ssd_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (code)
            5'h00:     seg = 7'h40;
            5'h01:     seg = 7'h79;
            5'h02:     seg = 7'h24;
            5'h03:     seg = 7'h30;
            5'h04:     seg = 7'h19;
            5'h05:     seg = 7'h12;
            5'h06:     seg = 7'h02;
            5'h07:     seg = 7'h78;
            5'h08:     seg = 7'h00;
            5'h09:     seg = 7'h10;
            5'h0A:     seg = 7'h08;
            5'h0B:     seg = 7'h03;
            5'h0C:     seg = 7'h46;
            5'h0D:     seg = 7'h21;
            5'h0E:     seg = 7'h06;
            5'h0F:     seg = 7'h0E;
            SYM_DASH:  seg = 7'h3F;
            SYM_L:     seg = 7'h47;
            SYM_P:     seg = 7'h0C;
            SYM_n:     seg = 7'h2B;
            SYM_U:     seg = 7'h41;
            SYM_r:     seg = 7'h2F;
            default:   seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode 7-seg scan driver with per-digit blinking and anti-ghost guard.
// Outputs are registered from next-state values so they line up with the scan counter.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned REFRESH_HZ = 1000,
    parameter int unsigned BLINK_HZ   = 1,
    parameter int unsigned GUARD_CYC  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [19:0] ssd_word,
    input  logic [3:0]  blink_mask,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned SCAN_DIV   = CLK_HZ / REFRESH_HZ;
    localparam int unsigned BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned SCAN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]  GUARD_END  = SCAN_W'(GUARD_CYC);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [1:0]         SLOT_FIRST = 2'd3;

    if (SCAN_DIV <= GUARD_CYC) begin : g_bad_scan
        $error("ssd_scan_driver: SCAN_DIV must exceed GUARD_CYC");
    end
    if (BLINK_HALF < 1) begin : g_bad_blink
        $error("ssd_scan_driver: BLINK_HALF must be at least 1");
    end

    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic [1:0]         slot_q, slot_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic [3:0]         mask_q;
    slot_hold_t         hold_q, hold_d;
    logic [3:0]         an_d;
    logic [6:0]         seg_d, seg_dec;
    logic               dp_d;
    logic               scan_wrap, hidden;

    sym_to_seg u_sym_to_seg (
        .code (hold_d.code),
        .seg  (seg_dec)
    );

    always_comb begin
        scan_wrap = (scan_q == SCAN_LAST);
        scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
        slot_d    = scan_wrap ? slot_q - 2'd1 : slot_q;

        // The slot's code is frozen for its whole duration to avoid mid-slot glitches.
        hold_d = hold_q;
        if (scan_wrap) begin
            hold_d.code  = ssd_word[5*int'(slot_d) +: 5];
            hold_d.blink = blink_mask[slot_d];
            hold_d.dp    = dp_mask[slot_d];
        end

        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (blink_mask != mask_q) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        hidden = phase_d & hold_d.blink;
        an_d   = (!en || scan_d < GUARD_END) ? 4'b1111 : ~(4'b0001 << slot_d);
        seg_d  = hidden ? 7'h7F : seg_dec;
        dp_d   = hidden | ~hold_d.dp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q      <= '0;
            slot_q      <= SLOT_FIRST;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            mask_q      <= 4'b0000;
            hold_q      <= '{code: SYM_BLANK, blink: 1'b0, dp: 1'b0};
            an          <= 4'b1111;
            seg         <= 7'h7F;
            dp          <= 1'b1;
        end else begin
            scan_q      <= scan_d;
            slot_q      <= slot_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            mask_q      <= blink_mask;
            hold_q      <= hold_d;
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Randomized bench for ssd_scan_driver against a cycle-count based reference model.
module tb_ssd_scan_driver;

    localparam int CLK_HZ     = 1000;
    localparam int REFRESH_HZ = 100;
    localparam int BLINK_HZ   = 1;
    localparam int GUARD_CYC  = 2;
    localparam int SCAN_DIV   = CLK_HZ / REFRESH_HZ;
    localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);

    logic        clk = 1'b0;
    logic        rst, en;
    logic [19:0] ssd_word;
    logic [3:0]  blink_mask, dp_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles since reset and what the current slot latched.
    int         n;
    int         slot;
    int         bstart;
    logic [4:0] h_code;
    logic       h_blink, h_dp, e_en, in_rst;
    logic [3:0] prev_mask;

    ssd_scan_driver #(
        .CLK_HZ     (CLK_HZ),
        .REFRESH_HZ (REFRESH_HZ),
        .BLINK_HZ   (BLINK_HZ),
        .GUARD_CYC  (GUARD_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ssd_word   (ssd_word),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [4:0] c);
        case (c)
            5'h00: return 7'b1000000;
            5'h01: return 7'b1111001;
            5'h02: return 7'b0100100;
            5'h03: return 7'b0110000;
            5'h04: return 7'b0011001;
            5'h05: return 7'b0010010;
            5'h06: return 7'b0000010;
            5'h07: return 7'b1111000;
            5'h08: return 7'b0000000;
            5'h09: return 7'b0010000;
            5'h0A: return 7'b0001000;
            5'h0B: return 7'b0000011;
            5'h0C: return 7'b1000110;
            5'h0D: return 7'b0100001;
            5'h0E: return 7'b0000110;
            5'h0F: return 7'b0001110;
            5'h11: return 7'b0111111;
            5'h12: return 7'b1000111;
            5'h13: return 7'b0001100;
            5'h14: return 7'b0101011;
            5'h15: return 7'b1000001;
            5'h16: return 7'b0101111;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic model_reset();
        n         = 0;
        slot      = 3;
        bstart    = 0;
        h_code    = 5'h10;
        h_blink   = 1'b0;
        h_dp      = 1'b0;
        prev_mask = 4'b0000;
        e_en      = 1'b0;
        in_rst    = 1'b1;
    endtask

    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, hide;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            in_rst = 1'b0;
            n++;
            slot = 3 - (n / SCAN_DIV) % 4;
            if (n % SCAN_DIV == 0) begin
                h_code  = ssd_word[slot*5 +: 5];
                h_blink = blink_mask[slot];
                h_dp    = dp_mask[slot];
            end
            if (blink_mask != prev_mask) bstart = n;
            prev_mask = blink_mask;
            e_en = en;
        end
        #1;
        if (in_rst) begin
            e_an  = 4'b1111;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            hide  = (((n - bstart) / BLINK_HALF) % 2 == 1) && h_blink;
            e_an  = (!e_en || (n % SCAN_DIV) < GUARD_CYC) ? 4'b1111 : ~(4'b0001 << slot);
            e_seg = hide ? 7'h7F : ref_seg(h_code);
            e_dp  = hide ? 1'b1 : !h_dp;
        end
        check("an", an, e_an);
        check("seg", seg, e_seg);
        check("dp", dp, e_dp);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        ssd_word   = {5'h12, 5'h00, 5'h05, 5'h0D};
        blink_mask = 4'b0000;
        dp_mask    = 4'b0000;
        model_reset();
        #2;
        check("reset_an", an, 4'b1111);
        check("reset_seg", seg, 7'h7F);
        check("reset_dp", dp, 1'b1);
        run(3);
        rst = 1'b0;
        run(80);

        // Blinking digit 3, then move the blink to digit 2.
        blink_mask = 4'b1000;
        run(1100);
        blink_mask = 4'b0100;
        run(600);

        // Change the word in the middle of slot 2.
        begin
            int guard = 0;
            while (!(slot == 2 && n % SCAN_DIV == 5) && guard < 100) begin
                step();
                guard++;
            end
            check("wait_slot2", guard < 100, 1);
        end
        ssd_word = {5'h13, 5'h14, 5'h15, 5'h16};
        run(50);

        en = 1'b0;
        run(25);
        en = 1'b1;
        run(40);

        // Out-of-table codes and decimal point on digit 0.
        blink_mask = 4'b0000;
        ssd_word   = {5'h17, 5'h1F, 5'h11, 5'h10};
        dp_mask    = 4'b0001;
        run(60);

        // Asynchronous reset in the middle of slot 1.
        begin
            int guard = 0;
            while (!(slot == 1 && n % SCAN_DIV == 5) && guard < 100) begin
                step();
                guard++;
            end
            check("wait_slot1", guard < 100, 1);
        end
        #2 rst = 1'b1;
        #1;
        check("async_rst_an", an, 4'b1111);
        check("async_rst_seg", seg, 7'h7F);
        check("async_rst_dp", dp, 1'b1);
        run(2);
        rst = 1'b0;
        run(60);

        // Random traffic on every input.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(19) == 0) ssd_word = 20'($urandom);
            if ($urandom_range(199) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(49) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(99) == 0) en = ~en;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
